instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decode/control unit of the RV32I core.
- Holds the PC and issues word-aligned requests to instruction memory over a valid/ready request channel with an in-order, variable-latency response channel.
- Buffers returned instruction words in a small FIFO and presents them to decode with a valid/ready handshake.
- Accepts branch/jump redirects (PCSrc and target from execute) and discards stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, instruction buffer entries; also the maximum number of in-flight requests (credit limit); legal range 1..8.

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  32  fetch address, bits[1:0] always 0
- imem_rsp_valid  input  1  response word valid; responses arrive in order, at least 1 cycle after acceptance
- imem_rsp_data  input  32  response instruction word
- redirect_valid  input  1  PCSrc from execute: change fetch stream
- redirect_target  input  32  new PC
- instr_valid  output  1  instr/instr_pc valid to decode
- instr_ready  input  1  decode consumes the head entry
- instr  output  32  instruction word to decode
- instr_pc  output  32  PC of instr
- instr_pc_plus4  output  32  instr_pc + 4, mod 2^32

Behaviour:
- Reset (async assert, sync-released internally via the flops): pc=RESET_PC, outstanding=0, drop_cnt=0, FIFO empty, imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=RESET_PC, instr_pc_plus4=RESET_PC+4.
- FSM: RESET_WAIT -> RUN. RESET_WAIT lasts exactly the first cycle after rst_n rises and issues no request. RUN issues requests.
- Issue rule (RUN): imem_req_valid=1 iff (outstanding + fifo_count) < DEPTH and redirect_valid=0. imem_req_addr=pc.
- A request is accepted when valid and ready are both 1: pc <= pc+4 (wraps), outstanding += 1.
- Response with drop_cnt=0: the word is written to the FIFO tail with its PC; outstanding -= 1. The credit rule guarantees the FIFO never overflows; a response into a full FIFO is an assertion error.
- Response with drop_cnt>0: the word is discarded; drop_cnt -= 1; outstanding -= 1.
- Accept and response in the same cycle: outstanding is unchanged.
- Latency: request accepted in cycle N, response in N+1, instr_valid=1 in N+2 (FIFO registered, no bypass).
- Decode handshake: head pops when instr_valid & instr_ready. Outputs show the head entry and hold stable while instr_valid=1 and instr_ready=0. When the FIFO is empty, instr_valid=0 and the other outputs hold their last values.
- Redirect (any state after RESET_WAIT) has priority over everything:
  - pc <= {redirect_target[31:2],2'b00}; FIFO flushed (fifo_count=0); no request issued that cycle.
  - drop_cnt <= outstanding; a response arriving in the same cycle is discarded and counted.
  - Any pop by decode in that cycle is ignored.
- New requests to the target may issue from the next cycle while stale responses drain. In-order return guarantees the stale ones arrive first.
- Back-to-back redirects: each one reloads pc and recomputes drop_cnt from the current outstanding count.
- Reset mid-operation: all state returns to reset values immediately. In-flight memory responses after reset are the memory's responsibility (the memory is reset on the same rst_n).

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds output ports perf_fetched (32) and perf_stall (32), both reset to 0.
  - perf_fetched increments on each decode pop.
  - perf_stall increments each RUN cycle with instr_valid=0 and redirect_valid=0.
  - Both wrap at 2^32.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset release, imem_req_ready=1, memory with 1-cycle latency returning addr-based words, instr_ready=1 → requests 0x0,0x4,0x8…; instr_valid first high in cycle 3 after reset; instr_pc sequence 0x0,0x4,0x8; instr_pc_plus4=instr_pc+4.
- instr_ready=0 for 10 cycles, DEPTH=2 → at most 2 requests accepted; then imem_req_valid=0; instr/instr_pc stable; on release, words for 0x0 and 0x4 pop in order with no loss.
- 2 requests in flight (0x8, 0xC), redirect_valid=1 with target 0x100 → both stale responses dropped; next instr_valid shows instr_pc=0x100; no request is issued in the redirect cycle.
- Redirect target 0x0000_0203 → imem_req_addr=0x200; a response arriving in the same cycle as the redirect is dropped.
- pc=0xFFFF_FFFC fetch → next request address 0x0000_0000; instr_pc_plus4=0x0000_0000.
- With FETCH_PERF_CNT_EN, 5 pops and a 3-cycle memory stall → perf_fetched=5, perf_stall counts exactly the empty, non-redirect RUN cycles.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : RV32I instruction fetch stage. Holds the PC, issues
//                word-aligned requests to instruction memory (valid/ready
//                request channel, in-order variable-latency responses),
//                buffers returned words in a DEPTH-entry FIFO and presents
//                them to decode with a valid/ready handshake. Redirects
//                from execute reload the PC, flush the FIFO and discard
//                stale in-flight responses.
//  Parameters  : RESET_PC - first fetch address after reset
//                DEPTH    - FIFO entries and in-flight request credit (1..8)
//  Ports       : clk, rst_n                   - clock / async active-low reset
//                imem_req_valid/ready/addr    - fetch request channel
//                imem_rsp_valid/data          - in-order fetch responses
//                redirect_valid/target        - PCSrc + target from execute
//                instr_valid/ready, instr,
//                instr_pc, instr_pc_plus4     - decode interface
//  Option      : `define FETCH_PERF_CNT_EN adds perf_fetched / perf_stall
//                32-bit wrapping counters (decode pops / empty RUN cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned      CNT_W    = 4;   // holds 0..8
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [31:0]      NOP      = 32'h0000_0013;

    typedef enum logic [0:0] {
        S_RESET_WAIT = 1'b0,
        S_RUN        = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] fifo_count_q, fifo_count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]      fifo_instr_q [DEPTH];
    logic [31:0]      fifo_instr_d [DEPTH];
    logic [31:0]      fifo_pc_q    [DEPTH];
    logic [31:0]      fifo_pc_d    [DEPTH];
    logic [31:0]      last_instr_q, last_instr_d;
    logic [31:0]      last_pc_q, last_pc_d;

    logic             req_valid;
    logic             accept;
    logic             redirect;
    logic             pop;
    logic             rsp_keep;
    logic             fifo_nonempty;
    logic [CNT_W:0]   credit_used;
    logic [31:0]      head_instr;
    logic [31:0]      head_pc;

    // Target low bits are forced to zero; only the word address matters.
    logic             unused_tgt_bits;
    assign unused_tgt_bits = ^redirect_target[1:0];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign fifo_nonempty = (fifo_count_q != '0);
    assign head_instr    = fifo_instr_q[rd_ptr_q];
    assign head_pc       = fifo_pc_q[rd_ptr_q];
    // Credits cover both in-flight requests and buffered words so a response
    // always finds a free FIFO slot.
    assign credit_used   = {1'b0, outstanding_q} + {1'b0, fifo_count_q};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        fifo_count_d  = fifo_count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        fifo_instr_d  = fifo_instr_q;
        fifo_pc_d     = fifo_pc_q;
        last_instr_d  = last_instr_q;
        last_pc_d     = last_pc_q;
        req_valid     = 1'b0;
        redirect      = 1'b0;

        case (state_q)
            S_RESET_WAIT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                redirect  = redirect_valid;
                req_valid = (credit_used < {1'b0, DEPTH_C}) && !redirect_valid;
            end
            default: begin
                state_d = S_RESET_WAIT;
            end
        endcase

        accept   = req_valid && imem_req_ready;
        pop      = fifo_nonempty && instr_ready && !redirect;
        rsp_keep = imem_rsp_valid && (drop_cnt_q == '0) && !redirect;

        outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(imem_rsp_valid);

        if (redirect) begin
            pc_d = {redirect_target[31:2], 2'b00};
            // Everything still in flight is stale; a response landing this
            // cycle is already being discarded, so it is not counted again.
            drop_cnt_d = outstanding_q - CNT_W'(imem_rsp_valid);
        end else begin
            if (accept) begin
                pc_d = pc_q + 32'd4;
            end
            if (imem_rsp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
        end

        // Capture the head before it leaves so the outputs hold their last
        // value once the FIFO runs empty.
        if ((pop || redirect) && fifo_nonempty) begin
            last_instr_d = head_instr;
            last_pc_d    = head_pc;
        end

        if (redirect) begin
            fifo_count_d = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
        end else begin
            if (rsp_keep) begin
                fifo_instr_d[wr_ptr_q] = imem_rsp_data;
                fifo_pc_d[wr_ptr_q]    = pc_for_rsp(pc_q, outstanding_q, fifo_count_q);
                wr_ptr_d               = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            fifo_count_d = fifo_count_q + CNT_W'(rsp_keep) - CNT_W'(pop);
        end
    end

    // The oldest in-flight request address is pc minus 4 per outstanding
    // request; with drop_cnt==0 every outstanding request is live.
    function automatic logic [31:0] pc_for_rsp(input logic [31:0]      pc,
                                               input logic [CNT_W-1:0] outs,
                                               input logic [CNT_W-1:0] cnt);
        logic unused_cnt;
        unused_cnt = ^cnt;
        return pc - {26'd0, outs, 2'b00};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_RESET_WAIT;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            fifo_count_q  <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            last_instr_q  <= NOP;
            last_pc_q     <= RESET_PC;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc_q[i]    <= '0;
            end
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            fifo_count_q  <= fifo_count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            last_instr_q  <= last_instr_d;
            last_pc_q     <= last_pc_d;
            fifo_instr_q  <= fifo_instr_d;
            fifo_pc_q     <= fifo_pc_d;
        end
    end

    assign imem_req_valid = req_valid;
    assign imem_req_addr  = pc_q;
    assign instr_valid    = fifo_nonempty;
    assign instr          = fifo_nonempty ? head_instr : last_instr_q;
    assign instr_pc       = fifo_nonempty ? head_pc    : last_pc_q;
    assign instr_pc_plus4 = instr_pc + 32'd4;

`ifndef SYNTHESIS
    a_no_fifo_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(rsp_keep && (fifo_count_q == DEPTH_C)));
`endif

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_stall_d   = perf_stall_q;
        if (pop) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        if ((state_q == S_RUN) && !fifo_nonempty && !redirect_valid) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Directed scoreboard bench for instr_fetch_unit. Stimulus
//                pushes the expected fetch stream (PCs) into a queue; a
//                negedge monitor pops and compares on every decode pop. A
//                behavioural memory returns addr ^ 32'h5A5A_0003 after a
//                configurable number of cycles, in order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_pc_plus4  (instr_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_stall      (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } pend_t;

    pend_t       pending[$];
    logic [31:0] acc_log[$];
    logic [31:0] exp_q[$];
    int unsigned cyc = 0;
    int unsigned lat = 1;
    int          acc_count = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          pops = 0;
    int          stall_model = 0;
    bit          perf_run = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0003;
    endfunction

    always @(posedge clk) cyc = cyc + 1;

    // Memory: accept on negedge sample, respond 'lat' cycles later in order.
    always @(negedge clk) begin
        if (rst_n && imem_req_valid && imem_req_ready) begin
            pending.push_back('{addr: imem_req_addr, due: cyc + lat});
            acc_log.push_back(imem_req_addr);
            acc_count++;
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            pending.delete();
            imem_rsp_valid = 1'b0;
        end else if (pending.size() > 0 && pending[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pending[0].addr);
            void'(pending.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
        end
    end

    // Scoreboard monitor: a pop happens at the next edge when these hold.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst_n) begin
            stall_model = 0;
        end else begin
            if (perf_run && !instr_valid && !redirect_valid) stall_model++;
            if (instr_valid && instr_ready && !redirect_valid) begin
                pops++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL pop_unexpected: got pc %h, expected no pop", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (instr_pc !== e || instr !== mem_word(e) || instr_pc_plus4 !== e + 32'd4) begin
                        miscompares++;
                        $display("FAIL pop_stream: got pc %h instr %h pc4 %h, expected pc %h instr %h pc4 %h",
                                 instr_pc, instr, instr_pc_plus4, e, mem_word(e), e + 32'd4);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_stream(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic wait_pops(input string name, input int n);
        int target;
        int i;
        target = pops + n;
        i = 0;
        while (pops < target && i < 100) begin
            tick();
            i++;
        end
        check(name, 32'(pops), 32'(target));
    endtask

    task automatic wait_pend(input string name, input int sz, input logic [31:0] head);
        bit hit;
        int i;
        hit = 1'b0;
        i = 0;
        while (!hit && i < 100) begin
            @(negedge clk);
            #2;
            if (pending.size() == sz && pending[0].addr == head) hit = 1'b1;
            i++;
        end
        check(name, 32'(hit), 32'd1);
    endtask

    // Asynchronous assert mid-cycle, checked before any clock edge, then
    // release just after an edge so RESET_WAIT spans one full cycle.
    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        perf_run = 1'b0;
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, NOP);
        check("rst_instr_pc", instr_pc, RESET_PC);
        check("rst_instr_pc4", instr_pc_plus4, RESET_PC + 32'd4);
        push_stream(RESET_PC);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("reset_wait_no_req", 32'(imem_req_valid), 32'd0);
    endtask

    initial begin
        int a0;
        int i;
        #1;

        // 1) Basic stream and first-valid latency.
        lat = 1;
        do_reset();
        tick();
        perf_run = 1'b1;
        check("c1_req_valid", 32'(imem_req_valid), 32'd1);
        check("c1_req_addr", imem_req_addr, RESET_PC);
        check("c1_instr_valid", 32'(instr_valid), 32'd0);
        tick();
        check("c2_instr_valid", 32'(instr_valid), 32'd0);
        tick();
        check("c3_instr_valid", 32'(instr_valid), 32'd1);
        check("c3_instr_pc", instr_pc, RESET_PC);
        wait_pops("t1_pops", 4);

        // 2) Decode back-pressure: credit limit caps accepted requests.
        instr_ready = 1'b0;
        do_reset();
        a0 = acc_count;
        for (int k = 0; k < 10; k++) tick();
        check("bp_accepts", 32'(acc_count - a0), 32'd2);
        check("bp_req_valid", 32'(imem_req_valid), 32'd0);
        check("bp_instr_valid", 32'(instr_valid), 32'd1);
        check("bp_instr_pc", instr_pc, RESET_PC);
        check("bp_instr", instr, mem_word(RESET_PC));
        instr_ready = 1'b1;
        wait_pops("bp_release_pops", 4);

        // 3) Redirect with 0x8 and 0xC in flight; 0x8 returns in the redirect cycle.
        lat = 2;
        do_reset();
        wait_pend("t3_inflight", 2, 32'h0000_0008);
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0100;
        push_stream(32'h0000_0100);
        #1;
        check("t3_redir_no_req", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("t3_req_addr", imem_req_addr, 32'h0000_0100);
        wait_pops("t3_pops", 3);

        // 4) Unaligned target; the one in-flight response lands with the redirect.
        lat = 1;
        do_reset();
        wait_pend("t4_inflight", 1, RESET_PC);
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0203;
        push_stream(32'h0000_0200);
        #1;
        check("t4_redir_no_req", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("t4_req_valid", 32'(imem_req_valid), 32'd1);
        check("t4_req_addr", imem_req_addr, 32'h0000_0200);
        wait_pops("t4_pops", 3);

        // 5) PC wrap at the top of the address space.
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        push_stream(32'hFFFF_FFFC);
        a0 = acc_count;
        tick();
        redirect_valid = 1'b0;
        i = 0;
        while (acc_count < a0 + 2 && i < 50) begin
            tick();
            i++;
        end
        check("wrap_accepts", 32'(acc_count >= a0 + 2), 32'd1);
        if (acc_count >= a0 + 2) begin
            check("wrap_addr0", acc_log[a0], 32'hFFFF_FFFC);
            check("wrap_addr1", acc_log[a0 + 1], 32'h0000_0000);
        end
        wait_pops("wrap_pops", 3);

        // 6) Back-to-back redirects: the last one wins.
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0300;
        tick();
        redirect_target = 32'h0000_0400;
        push_stream(32'h0000_0400);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("b2b_req_addr", imem_req_addr, 32'h0000_0400);
        wait_pops("b2b_pops", 3);

`ifdef FETCH_PERF_CNT_EN
        // 7) Performance counters: 5 pops with a 3-cycle memory stall.
        do_reset();
        perf_run = 1'b1;
        a0 = pops;
        i = 0;
        while (pops < a0 + 5 && i < 100) begin
            if (pops == a0 + 2 && imem_req_ready) begin
                imem_req_ready = 1'b0;
                tick();
                tick();
                tick();
                imem_req_ready = 1'b1;
            end
            tick();
            i++;
        end
        instr_ready = 1'b0;
        tick();
        tick();
        check("perf_fetched", perf_fetched, 32'd5);
        check("perf_stall", perf_stall, 32'(stall_model));
        instr_ready = 1'b1;
`endif

        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
